// File: rtl/i2c_seq_pkg.sv
// Shared types for the i2c register sequencer.
// States, status codes and read/write flag values.
package i2c_seq_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_BUS = 3'd1;
   localparam logic [2:0] ST_REG      = 3'd2;
   localparam logic [2:0] ST_WDATA    = 3'd3;
   localparam logic [2:0] ST_RSTART   = 3'd4;
   localparam logic [2:0] ST_RDATA    = 3'd5;
   localparam logic [2:0] ST_DONE     = 3'd6;

   typedef enum logic [2:0] {
      STS_OK        = 3'd0,
      STS_ADDR_NACK = 3'd1,
      STS_REG_NACK  = 3'd2,
      STS_DATA_NACK = 3'd3,
      STS_ARB_LOST  = 3'd4,
      STS_TIMEOUT   = 3'd5
   } status_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_reg_sequencer_if.sv
// Command/response bundle and byte-engine bundle.
// master drives requests, slave answers them.
interface i2c_seq_cmd_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rw;
   logic [6:0] cmd_dev;
   logic [7:0] cmd_reg;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [2:0] rsp_status;
   logic [7:0] rsp_rdata;
   logic       busy;

   modport master (
      output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_status, rsp_rdata, busy
   );
   modport slave (
      input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_status, rsp_rdata, busy
   );
endinterface

interface i2c_seq_eng_if;
   logic [7:0] m_address;
   logic       m_transfer_start;
   logic       m_transfer_continues;
   logic [7:0] m_data_tx;
   logic       m_transfer_ready;
   logic       m_interrupt;
   logic       m_transaction_complete;
   logic       m_nack;
   logic       m_address_err;
   logic       m_arbitration_err;
   logic [7:0] m_data_rx;

   modport master (
      output m_address, m_transfer_start,
      output m_transfer_continues, m_data_tx,
      input  m_transfer_ready, m_interrupt,
      input  m_transaction_complete, m_nack,
      input  m_address_err, m_arbitration_err, m_data_rx
   );
   modport slave (
      input  m_address, m_transfer_start,
      input  m_transfer_continues, m_data_tx,
      output m_transfer_ready, m_interrupt,
      output m_transaction_complete, m_nack,
      output m_address_err, m_arbitration_err, m_data_rx
   );
endinterface

// File: rtl/i2c_seq_timeout.sv
// Saturating watchdog: counts enabled cycles since the
// last clear and flags when LIMIT is reached (0 = never).
module i2c_seq_timeout #(
   parameter int LIMIT = 1000000
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

   logic [W-1:0] cnt;

   // count up while enabled, hold at the limit
   always_ff @(posedge clk_in) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable && (cnt != W'(LIMIT))) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = (LIMIT != 0) && (cnt == W'(LIMIT));

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register write/read command sequencer for the i2c byte
// engine, with arbitration retry and stuck-bus timeout.
module i2c_reg_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRIES    = 3
) (
   input  logic          clk_in,
   input  logic          reset,
   i2c_seq_cmd_if.slave  cmd,
   i2c_seq_eng_if.master eng
);

   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   logic [2:0]    state, state_n;
   logic [2:0]    status_q, status_n;
   logic [7:0]    rdata_q;
   logic          lat_rw;
   logic [6:0]    lat_dev;
   logic [7:0]    lat_reg;
   logic [7:0]    lat_wdata;
   logic [RW-1:0] retries;
   logic          retry_inc;
   logic          capture;
   logic          reg_hit, reg_hit_n;
   logic          accept, active, irq, arb_hit, nack_hit;
   logic          expired, to_clear;
   logic [7:0]    m_addr, m_tx;
   logic          m_start, m_cont;

   assign accept   = cmd.cmd_valid && cmd.cmd_ready;
   assign active   = (state != ST_IDLE) && (state != ST_DONE);
   assign irq      = eng.m_interrupt;
   assign arb_hit  = active && eng.m_arbitration_err;
   assign nack_hit = irq && eng.m_nack &&
                     ((state == ST_REG && eng.m_transaction_complete) ||
                      state == ST_WDATA);
   assign reg_hit_n = (state == ST_REG) && (reg_hit || irq);
   assign to_clear  = (state_n != state) || irq || arb_hit;

   i2c_seq_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_in  (clk_in),
      .reset   (reset),
      .clear   (to_clear),
      .enable  (active),
      .expired (expired)
   );

   // next state and status, highest-priority event first
   always_comb begin
      state_n   = state;
      status_n  = status_q;
      retry_inc = 1'b0;
      capture   = 1'b0;
      if (state == ST_IDLE) begin
         if (accept) state_n = ST_WAIT_BUS;
      end else if (state == ST_DONE) begin
         state_n = ST_IDLE;
      end else if (arb_hit) begin
         if (int'(retries) < MAX_RETRIES) begin
            retry_inc = 1'b1;
            state_n   = ST_WAIT_BUS;
         end else begin
            status_n = STS_ARB_LOST;
            state_n  = ST_DONE;
         end
      end else if (irq && eng.m_address_err) begin
         status_n = STS_ADDR_NACK;
         state_n  = ST_DONE;
      end else if (nack_hit) begin
         status_n = (state == ST_REG) ? STS_REG_NACK : STS_DATA_NACK;
         state_n  = ST_DONE;
      end else if (expired) begin
         status_n = STS_TIMEOUT;
         state_n  = ST_DONE;
      end else begin
         case (state)
            ST_WAIT_BUS: begin
               if (eng.m_transfer_ready) state_n = ST_REG;
            end
            ST_REG: begin
               if (irq && eng.m_transaction_complete)
                  state_n = (lat_rw == RW_READ) ? ST_RSTART : ST_WDATA;
            end
            ST_WDATA: begin
               if (irq) begin
                  status_n = STS_OK;
                  state_n  = ST_DONE;
               end
            end
            ST_RSTART, ST_RDATA: begin
               if (irq && eng.m_transaction_complete) begin
                  capture  = 1'b1;
                  status_n = STS_OK;
                  state_n  = ST_DONE;
               end else if (irq && state == ST_RSTART) begin
                  state_n = ST_RDATA;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // state, latched command, retry count and result registers
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state     <= ST_IDLE;
         status_q  <= STS_OK;
         rdata_q   <= '0;
         lat_rw    <= RW_WRITE;
         lat_dev   <= '0;
         lat_reg   <= '0;
         lat_wdata <= '0;
         retries   <= '0;
         reg_hit   <= 1'b0;
      end else begin
         state    <= state_n;
         status_q <= status_n;
         reg_hit  <= (state_n == ST_REG) && reg_hit_n;
         if (accept) begin
            lat_rw    <= cmd.cmd_rw;
            lat_dev   <= cmd.cmd_dev;
            lat_reg   <= cmd.cmd_reg;
            lat_wdata <= cmd.cmd_wdata;
            retries   <= '0;
            status_q  <= STS_OK;
            rdata_q   <= '0;
         end else begin
            if (retry_inc) retries <= retries + RW'(1);
            if (capture) rdata_q <= eng.m_data_rx;
         end
      end
   end

   // engine requests are decoded from the next state so they
   // drop in the same cycle an error or retry is taken
   always_ff @(posedge clk_in) begin
      if (reset) begin
         m_start <= 1'b0;
         m_cont  <= 1'b0;
         m_addr  <= '0;
         m_tx    <= '0;
      end else begin
         m_start <= 1'b0;
         m_cont  <= 1'b0;
         m_addr  <= '0;
         m_tx    <= '0;
         case (state_n)
            ST_REG: begin
               m_start <= !reg_hit_n;
               m_cont  <= 1'b1;
               m_addr  <= {lat_dev, 1'b0};
               m_tx    <= lat_reg;
            end
            ST_WDATA: begin
               m_addr <= {lat_dev, 1'b0};
               m_tx   <= lat_wdata;
            end
            ST_RSTART: begin
               m_start <= 1'b1;
               m_addr  <= {lat_dev, 1'b1};
            end
            ST_RDATA: begin
               m_addr <= {lat_dev, 1'b1};
            end
            default: ;
         endcase
      end
   end

   assign eng.m_address            = m_addr;
   assign eng.m_transfer_start     = m_start;
   assign eng.m_transfer_continues = m_cont;
   assign eng.m_data_tx            = m_tx;

   assign cmd.rsp_valid  = (state == ST_DONE);
   assign cmd.cmd_ready  = (state == ST_IDLE) && !cmd.rsp_valid && !reset;
   assign cmd.rsp_status = cmd.rsp_valid ? status_q : 3'd0;
   assign cmd.rsp_rdata  = cmd.rsp_valid ? rdata_q : 8'd0;
   assign cmd.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural
// byte-engine model and a response scoreboard.
module tb_i2c_reg_sequencer;

   localparam int LAT       = 3;
   localparam int TOK_START = 256;
   localparam int TOK_SR    = 257;
   localparam int TOK_STOP  = 258;
   localparam int TOK_NACK  = 259;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;

   always #5 clk_in = ~clk_in;

   i2c_seq_cmd_if cmd_if ();
   i2c_seq_eng_if eng_if ();

   i2c_reg_sequencer #(
      .TIMEOUT_CYCLES (500),
      .MAX_RETRIES    (3)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .cmd    (cmd_if),
      .eng    (eng_if)
   );

   typedef struct {
      logic [2:0] st;
      logic [7:0] rd;
   } exp_t;

   exp_t sb[$];
   int   bus_log[$];
   int   exp_bus[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc_cyc = 0;
   int   rsp_cyc = 0;

   // engine model configuration
   logic [6:0] present    = 7'h50;
   logic [7:0] slave_val  = 8'h00;
   bit         nack_reg   = 0;
   bit         nack_wdata = 0;
   bit         stall      = 0;
   int         arb_left   = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // behavioural i2c byte engine
   initial begin : engine
      int ph;
      int cnt;
      int wbytes;
      bit held;
      bit nk;
      logic [7:0] cur_addr;
      ph = 0; cnt = 0; wbytes = 0; held = 0; cur_addr = '0;
      eng_if.m_transfer_ready       = 1'b1;
      eng_if.m_interrupt            = 1'b0;
      eng_if.m_transaction_complete = 1'b0;
      eng_if.m_nack                 = 1'b0;
      eng_if.m_address_err          = 1'b0;
      eng_if.m_arbitration_err      = 1'b0;
      eng_if.m_data_rx              = 8'h00;
      forever begin
         @(negedge clk_in);
         eng_if.m_interrupt            = 1'b0;
         eng_if.m_transaction_complete = 1'b0;
         eng_if.m_nack                 = 1'b0;
         eng_if.m_address_err          = 1'b0;
         eng_if.m_arbitration_err      = 1'b0;
         if (reset) begin
            ph = 0;
            held = 0;
            eng_if.m_transfer_ready = 1'b1;
         end else begin
            case (ph)
               0: begin
                  if (eng_if.m_transfer_start) begin
                     eng_if.m_transfer_ready = 1'b0;
                     if (stall) begin
                        ph = 3;
                     end else if (arb_left > 0 && !held) begin
                        ph = 4;
                        cnt = LAT;
                     end else begin
                        bus_log.push_back(held ? TOK_SR : TOK_START);
                        if (!held) wbytes = 0;
                        cur_addr = eng_if.m_address;
                        bus_log.push_back(int'(cur_addr));
                        ph = 1;
                        cnt = LAT;
                     end
                  end else if (held) begin
                     ph = 2;
                     cnt = LAT;
                  end
               end
               1: begin
                  cnt--;
                  if (cnt == 0) begin
                     eng_if.m_interrupt = 1'b1;
                     if (cur_addr[7:1] != present) begin
                        eng_if.m_address_err = 1'b1;
                        eng_if.m_nack = 1'b1;
                        eng_if.m_transaction_complete = 1'b1;
                        bus_log.push_back(TOK_STOP);
                        ph = 0;
                        held = 0;
                        eng_if.m_transfer_ready = 1'b1;
                     end else begin
                        ph = 2;
                        cnt = LAT;
                     end
                  end
               end
               2: begin
                  cnt--;
                  if (cnt == 0) begin
                     eng_if.m_interrupt = 1'b1;
                     eng_if.m_transaction_complete = 1'b1;
                     ph = 0;
                     if (cur_addr[0]) begin
                        eng_if.m_data_rx = slave_val;
                        bus_log.push_back(int'(slave_val));
                        bus_log.push_back(TOK_NACK);
                        bus_log.push_back(TOK_STOP);
                        eng_if.m_nack = 1'b1;
                        held = 0;
                        eng_if.m_transfer_ready = 1'b1;
                     end else begin
                        nk = (wbytes == 0) ? nack_reg : nack_wdata;
                        wbytes++;
                        bus_log.push_back(int'(eng_if.m_data_tx));
                        eng_if.m_nack = nk;
                        if (nk || !eng_if.m_transfer_continues) begin
                           bus_log.push_back(TOK_STOP);
                           held = 0;
                           eng_if.m_transfer_ready = 1'b1;
                        end else begin
                           held = 1;
                        end
                     end
                  end
               end
               3: begin
                  if (!stall) begin
                     ph = 0;
                     eng_if.m_transfer_ready = 1'b1;
                  end
               end
               4: begin
                  cnt--;
                  if (cnt == 0) begin
                     eng_if.m_arbitration_err = 1'b1;
                     arb_left--;
                     ph = 0;
                     eng_if.m_transfer_ready = 1'b1;
                  end
               end
               default: ph = 0;
            endcase
         end
      end
   end

   // response monitor: pops the scoreboard on every rsp_valid
   initial begin : monitor
      bit prev;
      exp_t e;
      prev = 0;
      forever begin
         @(negedge clk_in);
         if (cmd_if.rsp_valid) begin
            chk("rsp_pulse_prev", int'(prev), 0);
            total++;
            assert (sb.size() > 0) else begin
               bad++;
               $error("FAIL unexpected_rsp observed=%0d expected=0",
                      cmd_if.rsp_status);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("rsp_status", int'(cmd_if.rsp_status), int'(e.st));
               chk("rsp_rdata", int'(cmd_if.rsp_rdata), int'(e.rd));
            end
         end
         prev = cmd_if.rsp_valid;
      end
   end

   task automatic send(input logic rw, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wd,
                       input bit push, input logic [2:0] st,
                       input logic [7:0] rd);
      bit ok;
      exp_t e;
      ok = 0;
      @(negedge clk_in);
      cmd_if.cmd_rw    = rw;
      cmd_if.cmd_dev   = dev;
      cmd_if.cmd_reg   = rg;
      cmd_if.cmd_wdata = wd;
      cmd_if.cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (cmd_if.cmd_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk_in);
      end
      chk("cmd_accept", int'(ok), 1);
      if (push) begin
         e.st = st;
         e.rd = rd;
         sb.push_back(e);
      end
      acc_cyc = cyc;
      @(negedge clk_in);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input string tag, input logic rw,
                          input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic [2:0] st,
                          input logic [7:0] rd);
      bit got;
      got = 0;
      bus_log.delete();
      send(rw, dev, rg, wd, 1, st, rd);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_in);
         if (cmd_if.rsp_valid) begin
            got = 1;
            break;
         end
      end
      rsp_cyc = cyc;
      chk({tag, "_rsp_seen"}, int'(got), 1);
      chk({tag, "_ready_lo"}, int'(cmd_if.cmd_ready), 0);
      @(negedge clk_in);
      chk({tag, "_ready_hi"}, int'(cmd_if.cmd_ready), 1);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic check_bus(input string tag);
      int n;
      chk({tag, "_bus_len"}, bus_log.size(), exp_bus.size());
      n = (bus_log.size() < exp_bus.size()) ? bus_log.size() : exp_bus.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_bus%0d", tag, i), bus_log[i], exp_bus[i]);
      exp_bus.delete();
   endtask

   initial begin : main
      bit seen;
      int lat;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_rw    = 1'b0;
      cmd_if.cmd_dev   = '0;
      cmd_if.cmd_reg   = '0;
      cmd_if.cmd_wdata = '0;
      repeat (3) @(negedge clk_in);
      chk("rst_busy", int'(cmd_if.busy), 0);
      chk("rst_rsp_valid", int'(cmd_if.rsp_valid), 0);
      chk("rst_start", int'(eng_if.m_transfer_start), 0);
      chk("rst_addr", int'(eng_if.m_address), 0);
      chk("rst_ready", int'(cmd_if.cmd_ready), 0);
      reset = 1'b0;
      @(negedge clk_in);
      chk("rel_ready", int'(cmd_if.cmd_ready), 1);

      exp_bus = '{TOK_START, 'hA0, 'h10, 'hA5, TOK_STOP};
      run_cmd("wr_ok", 1'b0, 7'h50, 8'h10, 8'hA5, 3'd0, 8'h00);
      check_bus("wr_ok");

      slave_val = 8'h3C;
      exp_bus = '{TOK_START, 'hA0, 'h22, TOK_SR, 'hA1, 'h3C,
                  TOK_NACK, TOK_STOP};
      run_cmd("rd_ok", 1'b1, 7'h50, 8'h22, 8'h00, 3'd0, 8'h3C);
      check_bus("rd_ok");

      exp_bus = '{TOK_START, 'h22, TOK_STOP};
      run_cmd("addr_nack", 1'b1, 7'h11, 8'h05, 8'h00, 3'd1, 8'h00);
      check_bus("addr_nack");

      nack_reg = 1;
      exp_bus = '{TOK_START, 'hA0, 'h10, TOK_STOP};
      run_cmd("reg_nack", 1'b0, 7'h50, 8'h10, 8'h55, 3'd2, 8'h00);
      check_bus("reg_nack");
      nack_reg = 0;

      nack_wdata = 1;
      run_cmd("data_nack", 1'b0, 7'h50, 8'h11, 8'h66, 3'd3, 8'h00);
      nack_wdata = 0;

      arb_left = 2;
      exp_bus = '{TOK_START, 'hA0, 'h12, 'h77, TOK_STOP};
      run_cmd("arb2", 1'b0, 7'h50, 8'h12, 8'h77, 3'd0, 8'h00);
      check_bus("arb2");
      chk("arb2_used", arb_left, 0);

      arb_left = 4;
      run_cmd("arb4", 1'b0, 7'h50, 8'h13, 8'h88, 3'd4, 8'h00);
      chk("arb4_used", arb_left, 0);

      stall = 1;
      run_cmd("timeout", 1'b0, 7'h50, 8'h14, 8'h99, 3'd5, 8'h00);
      lat = rsp_cyc - acc_cyc;
      chk("timeout_latency", int'(lat >= 500 && lat <= 510), 1);
      stall = 0;
      repeat (3) @(negedge clk_in);

      slave_val = 8'h5A;
      run_cmd("rd_after_to", 1'b1, 7'h50, 8'h30, 8'h00, 3'd0, 8'h5A);

      seen = 0;
      send(1'b0, 7'h50, 8'h40, 8'hC3, 0, 3'd0, 8'h00);
      for (int i = 0; i < 50; i++) begin
         if (eng_if.m_transfer_start) begin
            seen = 1;
            break;
         end
         @(negedge clk_in);
      end
      chk("mid_reg_seen", int'(seen), 1);
      reset = 1'b1;
      @(negedge clk_in);
      chk("mrst_start", int'(eng_if.m_transfer_start), 0);
      chk("mrst_cont", int'(eng_if.m_transfer_continues), 0);
      chk("mrst_addr", int'(eng_if.m_address), 0);
      chk("mrst_tx", int'(eng_if.m_data_tx), 0);
      chk("mrst_busy", int'(cmd_if.busy), 0);
      chk("mrst_rsp", int'(cmd_if.rsp_valid), 0);
      chk("mrst_ready", int'(cmd_if.cmd_ready), 0);
      @(negedge clk_in);
      reset = 1'b0;
      @(negedge clk_in);
      chk("mrst_ready_after", int'(cmd_if.cmd_ready), 1);
      repeat (20) @(negedge clk_in);

      exp_bus = '{TOK_START, 'hA0, 'h41, 'hE7, TOK_STOP};
      run_cmd("wr_after_rst", 1'b0, 7'h50, 8'h41, 8'hE7, 3'd0, 8'h00);
      check_bus("wr_after_rst");

      repeat (5) @(negedge clk_in);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Command-level front end for the i2c_master byte engine.
- Accepts single-byte register write/read commands (7-bit device, 8-bit register, 8-bit data) over a valid/ready handshake.
- Sequences the engine through START, register-address byte, and data byte. Reads use a repeated START followed by a single read byte.
- Returns read data and a status code. Retries transactions lost to arbitration and aborts stuck transactions on a timeout.

Parameters:
- TIMEOUT_CYCLES, 1000000: clk_in cycles without an engine interrupt before the transaction aborts; 0 disables the timeout.
- MAX_RETRIES, 3: number of re-issues after arbitration_err before reporting failure.

Ports:
- clk_in  input  1  sole clock, same clock as i2c_master.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer accepts a command this cycle.
- cmd_rw  input  1  1 = read, 0 = write.
- cmd_dev  input  7  7-bit device address.
- cmd_reg  input  8  register address.
- cmd_wdata  input  8  write data (ignored for reads).
- rsp_valid  output  1  one-cycle pulse: command finished.
- rsp_status  output  3  0 OK, 1 ADDR_NACK, 2 REG_NACK, 3 DATA_NACK, 4 ARB_LOST, 5 TIMEOUT.
- rsp_rdata  output  8  read byte; valid with rsp_valid when the command was a read and status is OK, else 0.
- busy  output  1  command in flight.
- m_address  output  8  to i2c_master address ({dev, mode}).
- m_transfer_start  output  1  to i2c_master transfer_start.
- m_transfer_continues  output  1  to i2c_master transfer_continues.
- m_data_tx  output  8  to i2c_master data_tx.
- m_transfer_ready, m_interrupt, m_transaction_complete, m_nack, m_address_err, m_arbitration_err  input  1 each  from i2c_master.
- m_data_rx  input  8  from i2c_master data_rx.

Behaviour:
- Reset: all outputs 0, state IDLE, retry and timeout counters cleared. Reset mid-transaction drops the command silently; no rsp_valid is produced. The bus recovers via the engine's own bus_clear logic.
- Command handshake:
  - cmd_ready = (state == IDLE) and no rsp_valid this cycle.
  - A command is accepted when cmd_valid && cmd_ready; all cmd_* fields are latched on that edge.
- States:
  - IDLE: wait for a command, then go to WAIT_BUS.
  - WAIT_BUS: wait for m_transfer_ready = 1. The timeout counter runs here too.
  - REG: drive m_transfer_start = 1, m_transfer_continues = 1, m_address = {dev, 0}, m_data_tx = reg. Hold m_transfer_start until the first m_interrupt.
    - m_interrupt with m_address_err: finish with ADDR_NACK.
    - m_interrupt with m_transaction_complete and m_nack: finish with REG_NACK.
    - Ack and write: go to WDATA.
    - Ack and read: go to RSTART.
  - WDATA: m_transfer_start = 0, m_transfer_continues = 0, m_data_tx = wdata. On m_interrupt: finish OK, or DATA_NACK if m_nack.
  - RSTART/RDATA: m_transfer_start = 1 (repeated START), m_address = {dev, 1}, m_transfer_continues = 0. Deassert m_transfer_start after the first m_interrupt of this phase.
    - On the completing m_interrupt, capture m_data_rx and finish OK.
    - The master NACKs the last read byte; m_nack = 1 here is expected and is not an error.
  - DONE: pulse rsp_valid for one cycle with the status, then go to IDLE. A new command is accepted at the earliest on the cycle after DONE.
- Arbitration: m_arbitration_err in any non-IDLE state drops all m_* requests for one cycle.
  - If retries used < MAX_RETRIES: increment the retry count and return to WAIT_BUS with the same latched command.
  - Otherwise: finish ARB_LOST.
- Timeout: a counter resets on every m_interrupt and on each state change. Reaching TIMEOUT_CYCLES deasserts all m_* requests and finishes TIMEOUT.
- Priority when events coincide in one cycle: reset > arbitration_err > address_err > nack > timeout.
- busy = (state != IDLE).
- Outputs m_* are registered; a response is produced one cycle after the qualifying m_interrupt.
- The retry counter is sized by $clog2(MAX_RETRIES+1). The timeout counter is sized by $clog2(TIMEOUT_CYCLES+1) and saturates.

Decomposition:
- Package i2c_seq_pkg:
  - state enum (IDLE, WAIT_BUS, REG, WDATA, RSTART, RDATA, DONE).
  - status enum with the encodings above.
  - RW_READ/RW_WRITE constants.
- One sub-module, i2c_seq_timeout: a loadable saturating watchdog counter with clear/enable/expired signals.
- No further hierarchy.

Test Plan:
- Write dev 0x50 reg 0x10 data 0xA5, slave acks all:
  - bus shows START, 0xA0, 0x10, 0xA5, STOP.
  - rsp_valid for one cycle with status 0; cmd_ready returns 1 the cycle after.
- Read dev 0x50 reg 0x22, slave returns 0x3C:
  - bus shows START, 0xA0, 0x22, Sr, 0xA1, 0x3C, NACK, STOP.
  - rsp_rdata = 0x3C, status 0.
- Absent device 0x11: address NACK → status 1, rsp_rdata = 0, no data bytes on the bus.
- Slave NACKs register byte 0x10 → status 2. Slave NACKs write data → status 3.
- Arbitration:
  - Inject m_arbitration_err twice → two automatic re-issues, then status 0.
  - Inject it four times with MAX_RETRIES = 3 → status 4.
- Timeout and reset:
  - Hold SCL low with TIMEOUT_CYCLES = 500 → status 5 after 500 idle cycles.
  - Assert reset mid-REG → all outputs 0 next cycle, no rsp_valid, cmd_ready = 1 after release.
